alu_seq_unit: RTL and testbench

//  Sequential, handshaked ALU execution unit: accepts one operation (a, b, control) over a

---
 rtl/alu_seq_unit_pkg.sv | 57 +++++
 rtl/alu_seq_unit_alu.sv | 45 ++++
 rtl/alu_seq_unit.sv | 152 +++++++++++++++
 tb/tb_alu_seq_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_unit_pkg.sv
// Shared types for the sequential ALU unit: operation codes, FSM states,
// captured-request payload and small helpers.
package alu_seq_unit_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    // Operation select; codes 11..15 are undefined and yield result 0.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_NOR  = 4'd3,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_seq_state_t;

    // Request payload held for the whole lifetime of one operation.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_control_t      control;
    } alu_req_t;

    function automatic logic is_shift(input alu_control_t c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

    function automatic string alu_control_name(input alu_control_t c);
        case (c)
            ALU_AND:  return "AND";
            ALU_OR:   return "OR";
            ALU_XOR:  return "XOR";
            ALU_NOR:  return "NOR";
            ALU_ADD:  return "ADD";
            ALU_SUB:  return "SUB";
            ALU_SLT:  return "SLT";
            ALU_SLTU: return "SLTU";
            ALU_SLL:  return "SLL";
            ALU_SRL:  return "SRL";
            ALU_SRA:  return "SRA";
            default:  return "UNDEF";
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_unit_alu.sv
// Combinational ALU: logic ops, add/sub with signed overflow, SLT/SLTU.
// Ports: a, b operands; control op select; result_c, overflow_c combinational
// outputs. Shift and undefined codes return 0 (shifts are done elsewhere).
module alu
    import alu_seq_unit_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_control_t control,
    output logic [N-1:0] result_c,
    output logic         overflow_c
);

    logic         is_sub_c;
    logic [N-1:0] b_eff_c;
    logic [N-1:0] sum_c;

    // SUB is a + ~b + 1 so both ops share one adder and one overflow rule.
    always_comb begin
        is_sub_c = (control == ALU_SUB);
        b_eff_c  = is_sub_c ? ~b : b;
        sum_c    = a + b_eff_c + N'(is_sub_c);
    end

    always_comb begin
        result_c   = '0;
        overflow_c = 1'b0;
        case (control)
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_NOR:  result_c = ~(a | b);
            ALU_ADD, ALU_SUB: begin
                result_c   = sum_c;
                overflow_c = (a[N-1] == b_eff_c[N-1]) && (sum_c[N-1] != a[N-1]);
            end
            ALU_SLT:  result_c = N'($signed(a) < $signed(b));
            ALU_SLTU: result_c = N'(a < b);
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU unit. One request is captured over req_valid/
// req_ready, executed (combinational alu or iterative 1-bit/cycle shifter) and
// returned with flags over rsp_valid/rsp_ready.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b/req_control request
// channel; rsp_valid/rsp_ready/rsp_result/rsp_overflow/rsp_zero/rsp_equal
// response channel; busy = unit not idle.
module alu_seq_unit
    import alu_seq_unit_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  alu_control_t req_control,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_overflow,
    output logic         rsp_zero,
    output logic         rsp_equal,
    output logic         busy
);

    alu_seq_state_t       state;
    alu_seq_state_t       state_next;
    alu_req_t             req_q;
    logic [N-1:0]         work;
    logic [SHAMT_W-1:0]   cnt;

    logic                 accept_c;
    logic                 rsp_load_c;
    logic                 rsp_take_c;
    logic [N-1:0]         shifted_c;
    logic [N-1:0]         alu_result_c;
    logic                 alu_overflow_c;
    logic [N-1:0]         final_c;
    logic                 final_ovf_c;

    alu #(.N(N)) u_alu (
        .a          (req_q.a),
        .b          (req_q.b),
        .control    (req_q.control),
        .result_c   (alu_result_c),
        .overflow_c (alu_overflow_c)
    );

    assign accept_c   = req_valid && req_ready;
    // First S_DONE cycle registers the result; rsp_valid follows one edge later.
    assign rsp_load_c = (state == S_DONE) && !rsp_valid;
    assign rsp_take_c = rsp_valid && rsp_ready;

    // One-bit step of the iterative shifter.
    always_comb begin
        shifted_c = work;
        case (req_q.control)
            ALU_SLL: shifted_c = work << 1;
            ALU_SRL: shifted_c = work >> 1;
            ALU_SRA: shifted_c = {work[N-1], work[N-1:1]};
            default: shifted_c = work;
        endcase
    end

    // Shift ops take the working register (holds a when shamt was 0).
    always_comb begin
        final_c     = alu_result_c;
        final_ovf_c = alu_overflow_c;
        if (is_shift(req_q.control)) begin
            final_c     = work;
            final_ovf_c = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (is_shift(req_control) && (req_b[SHAMT_W-1:0] != '0)) begin
                        state_next = S_SHIFT;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (cnt == SHAMT_W'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_take_c) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus state-derived registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= (state_next == S_IDLE);
            busy      <= (state_next != S_IDLE);
        end
    end

    // Capture, shifter and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
            work  <= '0;
            cnt   <= '0;
        end else if (accept_c) begin
            req_q <= '{a: req_a, b: req_b, control: req_control};
            work  <= req_a;
            cnt   <= req_b[SHAMT_W-1:0];
        end else if (state == S_SHIFT) begin
            work  <= shifted_c;
            cnt   <= cnt - SHAMT_W'(1);
        end
    end

    // Response registers; held stable until the handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_equal    <= 1'b0;
        end else if (rsp_load_c) begin
            rsp_valid    <= 1'b1;
            rsp_result   <= final_c;
            rsp_overflow <= final_ovf_c;
            rsp_zero     <= (final_c == '0);
            rsp_equal    <= (req_q.a == req_q.b);
        end else if (rsp_take_c) begin
            rsp_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit.
module tb_alu_seq_unit;
    import alu_seq_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_a;
    logic [31:0]  req_b;
    alu_control_t req_control;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_result;
    logic         rsp_overflow;
    logic         rsp_zero;
    logic         rsp_equal;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq_unit #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_control  (req_control),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_equal    (rsp_equal),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Directed table: hand-computed results.
    localparam int NV = 12;
    localparam alu_control_t TC [NV] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLT,
                                         ALU_SLTU, ALU_SUB, ALU_ADD, alu_control_t'(4'hF),
                                         ALU_ADD, ALU_SRL};
    localparam logic [31:0] TA [NV] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                        32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                                        32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h80000000};
    localparam logic [31:0] TB [NV] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                        32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001,
                                        32'h00000001, 32'h00000005, 32'h80000000, 32'h00000004};
    localparam logic [31:0] TR [NV] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
                                        32'h00000001, 32'h00000000, 32'h00000000, 32'h7FFFFFFF,
                                        32'h00000000, 32'h00000000, 32'h00000000, 32'h08000000};
    localparam logic        TO [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                        1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam int          TL [NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 5};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for req_ready, presents one request for exactly the accept edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input alu_control_t c);
        int w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (req_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_a       = a;
        req_b       = b;
        req_control = c;
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (rsp_valid !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
        if (rsp_valid !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_control = ALU_AND;
        tick(); tick();
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/valid/busy=%b required 100", {req_ready, rsp_valid, busy});
        end
        n_checks++;
        if ({rsp_result, rsp_overflow, rsp_zero, rsp_equal} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: result=%h ovf=%b zero=%b eq=%b required all 0",
                     rsp_result, rsp_overflow, rsp_zero, rsp_equal);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add_overflow();
        int lat;
        rsp_ready = 1'b1;
        issue(32'h7FFFFFFF, 32'h00000001, ALU_ADD);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d required 1", lat); end
        n_checks++;
        if ({rsp_result, rsp_overflow, rsp_zero, rsp_equal} !== {32'h80000000, 3'b100}) begin
            n_fail++;
            $display("FAIL add_rsp: result=%h ovf=%b zero=%b eq=%b required 80000000 1 0 0",
                     rsp_result, rsp_overflow, rsp_zero, rsp_equal);
        end
        tick();
        n_checks++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL add_after_hs: valid/ready/busy=%b required 010", {rsp_valid, req_ready, busy});
        end
    endtask

    task automatic test_sub_equal();
        int lat;
        rsp_ready = 1'b1;
        issue(32'h12345678, 32'h12345678, ALU_SUB);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d required 1", lat); end
        n_checks++;
        if ({rsp_result, rsp_overflow, rsp_zero, rsp_equal} !== {32'h0, 3'b011}) begin
            n_fail++;
            $display("FAIL sub_rsp: result=%h ovf=%b zero=%b eq=%b required 0 0 1 1",
                     rsp_result, rsp_overflow, rsp_zero, rsp_equal);
        end
        tick();
    endtask

    task automatic test_shifts();
        int lat;
        rsp_ready = 1'b1;
        issue(32'h80000000, 32'h0000001F, ALU_SRA);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 32) begin n_fail++; $display("FAIL sra31_latency: got %0d required 32", lat); end
        n_checks++;
        if (rsp_result !== 32'hFFFFFFFF || rsp_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL sra31_rsp: result=%h ovf=%b required FFFFFFFF 0", rsp_result, rsp_overflow);
        end
        tick();
        issue(32'hDEADBEEF, 32'h00000020, ALU_SLL);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL sll0_latency: got %0d required 1", lat); end
        n_checks++;
        if (rsp_result !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL sll0_rsp: result=%h required DEADBEEF", rsp_result);
        end
        tick();
        issue(32'h00000001, 32'h0000001F, ALU_SLL);
        wait_rsp(lat);
        n_checks++;
        if (lat !== 32 || rsp_result !== 32'h80000000) begin
            n_fail++;
            $display("FAIL sll31: latency=%0d result=%h required 32 80000000", lat, rsp_result);
        end
        tick();
    endtask

    task automatic test_table();
        int lat;
        rsp_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            issue(TA[i], TB[i], TC[i]);
            wait_rsp(lat);
            n_checks++;
            if (lat !== TL[i] || rsp_result !== TR[i] || rsp_overflow !== TO[i] ||
                rsp_zero !== (TR[i] == 32'h0) || rsp_equal !== (TA[i] == TB[i])) begin
                n_fail++;
                $display("FAIL table[%0d]: lat=%0d res=%h ovf=%b z=%b eq=%b required lat=%0d res=%h ovf=%b z=%b eq=%b",
                         i, lat, rsp_result, rsp_overflow, rsp_zero, rsp_equal,
                         TL[i], TR[i], TO[i], TR[i] == 32'h0, TA[i] == TB[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        rsp_ready = 1'b0;
        issue(32'h00000001, 32'hFFFFFFFF, ALU_SLTU);
        wait_rsp(lat);
        // Second request pending during backpressure.
        req_a = 32'h2; req_b = 32'h3; req_control = ALU_ADD; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h1 || rsp_zero !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b result=%h zero=%b req_ready=%b required 1 1 0 0",
                         i, rsp_valid, rsp_result, rsp_zero, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_after_hs: valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
        end
        tick();
        n_checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_accept: req_ready=%b busy=%b required 0 1", req_ready, busy);
        end
        req_valid = 1'b0;
        wait_rsp(lat);
        n_checks++;
        if (lat !== 1 || rsp_result !== 32'h5) begin
            n_fail++; $display("FAIL bp_second_rsp: lat=%0d result=%h required 1 00000005", lat, rsp_result);
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int stray = 0;
        rsp_ready = 1'b1;
        issue(32'h00000001, 32'h00000014, ALU_SLL);
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_shift_busy: busy=%b valid=%b required 1 0", busy, rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy, rsp_result, rsp_overflow, rsp_zero, rsp_equal} !== {3'b100, 35'd0}) begin
            n_fail++;
            $display("FAIL mid_shift_reset: ready=%b valid=%b busy=%b result=%h flags=%b%b%b required 1 0 0 0 000",
                     req_ready, rsp_valid, busy, rsp_result, rsp_overflow, rsp_zero, rsp_equal);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid !== 1'b0) stray++;
            tick();
        end
        n_checks++;
        if (stray !== 0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_shift_no_rsp: stray_valid_cycles=%0d req_ready=%b required 0 1", stray, req_ready);
        end
    endtask

    // Independent reference using whole-word shifts and 64-bit arithmetic.
    function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        longint s;
        logic [31:0] r = '0;
        logic o = 1'b0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~(a | b);
            4'd4, 4'd5: begin
                if (c == 4'd4) s = longint'($signed(a)) + longint'($signed(b));
                else           s = longint'($signed(a)) - longint'($signed(b));
                r = s[31:0];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: r = (a < b) ? 32'd1 : 32'd0;
            4'd8: r = a << b[4:0];
            4'd9: r = a >> b[4:0];
            4'd10: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = '0;
        endcase
        return {o, r};
    endfunction

    task automatic test_random();
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic [3:0]  qc [$];
        logic [31:0] ea, eb, na, nb;
        logic [3:0]  ec, nc;
        logic [32:0] exp;
        logic        have = 1'b0;
        logic        fire_req, fire_rsp;
        int          sent = 0, got = 0, errs = 0;
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 30000 && got < 200; cyc++) begin
            if (!have && sent < 200) begin
                na = $urandom();
                nc = 4'($urandom_range(0, 15));
                nb = ($urandom_range(0, 7) == 0) ? na : $urandom();
                have = 1'b1;
            end
            req_a = na; req_b = nb; req_control = alu_control_t'(nc);
            req_valid = have && (req_valid || ($urandom_range(0, 2) != 0));
            rsp_ready = ($urandom_range(0, 2) != 0);
            fire_req = req_valid && req_ready;
            fire_rsp = rsp_valid && rsp_ready;
            if (fire_rsp) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_unexpected_rsp: result=%h with no request outstanding", rsp_result);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    exp = ref_model(ea, eb, ec);
                    n_checks++;
                    if (rsp_result !== exp[31:0] || rsp_overflow !== exp[32] ||
                        rsp_zero !== (exp[31:0] == 32'h0) || rsp_equal !== (ea == eb)) begin
                        n_fail++; errs++;
                        $display("FAIL rand[%0d] ctl=%0d a=%h b=%h: res=%h ovf=%b z=%b eq=%b required res=%h ovf=%b z=%b eq=%b",
                                 got, ec, ea, eb, rsp_result, rsp_overflow, rsp_zero, rsp_equal,
                                 exp[31:0], exp[32], exp[31:0] == 32'h0, ea == eb);
                    end
                end
                got++;
            end
            if (fire_req) begin
                qa.push_back(na); qb.push_back(nb); qc.push_back(nc);
                have = 1'b0;
                sent++;
            end
            tick();
            if (fire_req) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        n_checks++;
        if (got !== 200 || qa.size() !== 0) begin
            n_fail++;
            $display("FAIL rand_count: responses=%0d outstanding=%0d required 200 0", got, qa.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_equal();
        test_shifts();
        test_table();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
